// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op/state types and counter sizing for mult_div_unit
package muldiv_pkg;

    localparam int N_BIT_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } muldiv_state_t;

    // One extra bit so the counter can represent N_BIT itself.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

    localparam int CNT_W_DEFAULT = cnt_width(N_BIT_DEFAULT);

endpackage

// File: rtl/muldiv_abs.sv
// rtl/muldiv_abs.sv - conditional two's-complement negate (magnitude at launch, sign fix at finish)
module muldiv_abs #(
    parameter int W = 32
) (
    input  logic         signed_en_i,
    input  logic         neg_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o
);

    assign data_o = (signed_en_i && neg_i) ? (~data_i + W'(1)) : data_i;

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU with HI/LO; divide datapath present only with MULDIV_DIVIDE_EN
module mult_div_unit
    import muldiv_pkg::*;
#(
    parameter int N_BIT = N_BIT_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [N_BIT-1:0] rs_data_i,
    input  logic [N_BIT-1:0] rt_data_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [N_BIT-1:0] wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [N_BIT-1:0] hi_o,
    output logic [N_BIT-1:0] lo_o
);

    localparam int CW = cnt_width(N_BIT);
    localparam int AW = 2 * N_BIT + 1;

    muldiv_state_t    state_q, state_d;
    muldiv_op_t       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [N_BIT-1:0] opnd_q, opnd_d;
    logic             neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic [N_BIT-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic             launch_signed, launch_div, res_signed, is_div_q;
    logic [N_BIT-1:0] mag_a, mag_b;
    logic [N_BIT:0]   mul_sum;
    logic [AW-1:0]    mul_pre, mul_next;
    logic [2*N_BIT-1:0] prod_fix;

    assign launch_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
    assign launch_div    = (op_i == OP_DIV) || (op_i == OP_DIVU);
    assign res_signed    = (op_q == OP_MULT) || (op_q == OP_DIV);
    assign is_div_q      = (op_q == OP_DIV) || (op_q == OP_DIVU);

    muldiv_abs #(.W(N_BIT)) u_abs_a (
        .signed_en_i(launch_signed), .neg_i(rs_data_i[N_BIT-1]), .data_i(rs_data_i), .data_o(mag_a)
    );
    muldiv_abs #(.W(N_BIT)) u_abs_b (
        .signed_en_i(launch_signed), .neg_i(rt_data_i[N_BIT-1]), .data_i(rt_data_i), .data_o(mag_b)
    );
    muldiv_abs #(.W(2*N_BIT)) u_fix_prod (
        .signed_en_i(res_signed), .neg_i(neg_a_q ^ neg_b_q), .data_i(acc_q[2*N_BIT-1:0]), .data_o(prod_fix)
    );

    // Shift-add: multiplier sits in the low half and is consumed LSB first.
    assign mul_sum  = acc_q[AW-1:N_BIT] + {1'b0, opnd_q};
    assign mul_pre  = acc_q[0] ? {mul_sum, acc_q[N_BIT-1:0]} : acc_q;
    assign mul_next = {1'b0, mul_pre[AW-1:1]};

`ifdef MULDIV_DIVIDE_EN
    logic             div0_q, div0_d;
    logic [N_BIT:0]   div_trial;
    logic [AW-1:0]    div_next;
    logic [N_BIT-1:0] quo_fix, rem_fix;

    // Restoring step: remainder in the upper half, dividend shifts out as quotient shifts in.
    assign div_trial = acc_q[2*N_BIT-1:N_BIT-1] - {1'b0, opnd_q};
    assign div_next  = div_trial[N_BIT] ? {acc_q[AW-2:0], 1'b0}
                                        : {1'b0, div_trial[N_BIT-1:0], acc_q[N_BIT-2:0], 1'b1};

    muldiv_abs #(.W(N_BIT)) u_fix_quo (
        .signed_en_i(res_signed), .neg_i(neg_a_q ^ neg_b_q), .data_i(acc_q[N_BIT-1:0]), .data_o(quo_fix)
    );
    muldiv_abs #(.W(N_BIT)) u_fix_rem (
        .signed_en_i(res_signed), .neg_i(neg_a_q), .data_i(acc_q[2*N_BIT-1:N_BIT]), .data_o(rem_fix)
    );
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
`ifdef MULDIV_DIVIDE_EN
        div0_d  = div0_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (hi_we_i) hi_d = wdata_i;
                if (lo_we_i) lo_d = wdata_i;
                if (start_i) begin
                    op_d    = muldiv_op_t'(op_i);
                    neg_a_d = rs_data_i[N_BIT-1];
                    neg_b_d = rt_data_i[N_BIT-1];
                    cnt_d   = '0;
                    if (launch_div) begin
                        acc_d  = {{(N_BIT+1){1'b0}}, mag_a};
                        opnd_d = mag_b;
                    end else begin
                        acc_d  = {{(N_BIT+1){1'b0}}, mag_b};
                        opnd_d = mag_a;
                    end
`ifdef MULDIV_DIVIDE_EN
                    div0_d  = (rt_data_i == '0);
                    state_d = RUN;
`else
                    state_d = launch_div ? FINISH : RUN;
`endif
                end
            end
            RUN: begin
`ifdef MULDIV_DIVIDE_EN
                acc_d = is_div_q ? div_next : mul_next;
`else
                acc_d = mul_next;
`endif
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N_BIT - 1)) state_d = FINISH;
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end
`ifdef MULDIV_DIVIDE_EN
                else begin
                    lo_d = div0_q ? '1 : quo_fix;
                    hi_d = rem_fix;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            op_q    <= OP_MULT;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MULDIV_DIVIDE_EN
            div0_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MULDIV_DIVIDE_EN
            div0_q  <= div0_d;
`endif
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule
